// File: rtl/typedef_pkg.sv
// Shared transfer types for the wrapper/unwrapper data path.
package typedef_pkg;

  typedef logic [7:0] byte_t;
  typedef byte_t      data_byte_t;
  typedef data_byte_t payload_t;

  typedef struct packed {
    payload_t data;
    logic     valid;
  } transfer_t;

  localparam int unsigned PAYLOAD_W  = $bits(payload_t);
  localparam int unsigned TRANSFER_W = $bits(transfer_t);

endpackage

// File: rtl/transfer_fifo_ptr.sv
// Wrapping index counter 0..DEPTH-1; advances by one when inc is high.
module transfer_fifo_ptr #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [PTR_W-1:0] ptr
);

  // Explicit wrap so non-power-of-two depths stay in range.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == PTR_W'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/transfer_fifo.sv
// First-word-fall-through elastic buffer of transfer_t entries.
// Optional occupancy statistics enabled by defining TRANSFER_FIFO_STATS_EN.
module transfer_fifo
  import typedef_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  transfer_t        in_transfer,
  output logic             in_ready,
  output transfer_t        out_transfer,
  input  logic             out_ready,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
`ifdef TRANSFER_FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0] max_level,
  output logic [15:0]      drop_count
`endif
);

  payload_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] count_nxt;

  assign push = in_transfer.valid & in_ready;
  assign pop  = out_transfer.valid & out_ready;

  transfer_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  transfer_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // Storage holds data only; valid is regenerated from occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_transfer.data;
    end
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Flags are precomputed from the next count so they come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      in_ready <= 1'b1;
    end else begin
      count    <= count_nxt;
      full     <= (count_nxt == CNT_W'(DEPTH));
      empty    <= (count_nxt == '0);
      in_ready <= (count_nxt != CNT_W'(DEPTH));
    end
  end

  // Head is masked while empty so unwritten storage never reaches the port.
  always_comb begin
    out_transfer.valid = ~empty;
    out_transfer.data  = empty ? '0 : mem[rd_ptr];
  end

`ifdef TRANSFER_FIFO_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      max_level  <= '0;
      drop_count <= '0;
    end else begin
      if (count_nxt > max_level) begin
        max_level <= count_nxt;
      end
      if (in_transfer.valid && full && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end
`endif

endmodule
